// File: rtl/i2f16_pipe.sv
// i2f16_pipe: three-stage pipelined integer-to-FP16 (IEEE 754 binary16) converter.
//   Stage 1: sign extraction and magnitude (two's complement negate when signed).
//   Stage 2: leading-zero count and normalisation; unbiased exponent.
//   Stage 3: round-to-nearest-even, exponent bias, overflow to infinity, flags.
// Each stage advances when the stage downstream of it can take its contents,
// so bubbles collapse and a full pipe streams one word per cycle.
module i2f16_pipe #(
  parameter int WID = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic [WID-1:0] in_int,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    o,
  output logic           overflow,
  output logic           inexact
);

  // Exponent arithmetic width: unbiased exponent is at most 31, and with the
  // bias plus a rounding carry it stays below 64.
  localparam int EW = 6;
  // Bits below the hidden one, followed by 11 zeros so that the fraction,
  // guard and sticky positions exist even for narrow inputs.
  localparam int XW = WID + 10;

  if (WID < 8 || WID > 32) begin : g_wid_check
    $error("i2f16_pipe: WID must lie in 8..32");
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;

  // Stage 1 payload
  logic           sgn1_q, sgn1_d;
  logic [WID-1:0] mag1_q, mag1_d;
  logic           iz1_q,  iz1_d;

  // Stage 2 payload; norm holds only the bits below the hidden one, which is
  // implied to be 1 whenever the operand is non-zero.
  logic           sgn2_q,  sgn2_d;
  logic           iz2_q,   iz2_d;
  logic [WID-2:0] norm2_q, norm2_d;
  logic [EW-1:0]  e2_q,    e2_d;

  // Stage 3 payload (the registered outputs)
  logic [15:0] o_q,   o_d;
  logic        ovf_q, ovf_d;
  logic        inx_q, inx_d;

  // Stage enables and working values
  logic          adv1, adv2, adv3;
  logic [EW-1:0] lz;
  logic [XW-1:0] ext;
  logic [9:0]    frac;
  logic          g_bit, s_bit, rnd_up;
  logic [10:0]   frac_r;
  logic [EW-1:0] be;

  // Stage enables: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv3     = !v3_q || out_ready;
    adv2     = !v2_q || adv3;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
  end

  // Valid bits follow the predecessor when advancing, otherwise hold.
  always_comb begin
    v1_d = adv1 ? in_valid : v1_q;
    v2_d = adv2 ? v1_q     : v2_q;
    v3_d = adv3 ? v2_q     : v3_q;
  end

  // Stage 1: sign and magnitude of the incoming operand.
  always_comb begin
    // NOTE: every variable assigned here gets a default first (its held value),
    // so no path leaves it unassigned and no latch is inferred.
    sgn1_d = sgn1_q;
    mag1_d = mag1_q;
    iz1_d  = iz1_q;
    if (adv1 && in_valid) begin
      sgn1_d = op & in_int[WID-1];
      // Negating the most negative signed value wraps back to 2^(WID-1),
      // which read as unsigned is exactly its magnitude.
      mag1_d = sgn1_d ? -in_int : in_int;
      iz1_d  = (in_int == '0);
    end
  end

  // Stage 2: leading-zero count, normalise, unbiased exponent.
  always_comb begin
    // Ascending scan: the highest set bit is the last to write lz.
    lz = EW'(WID);
    for (int i = 0; i < WID; i++) begin
      if (mag1_q[i]) lz = EW'(WID - 1 - i);
    end
    sgn2_d  = sgn2_q;
    iz2_d   = iz2_q;
    norm2_d = norm2_q;
    e2_d    = e2_q;
    if (adv2 && v1_q) begin
      sgn2_d  = sgn1_q;
      iz2_d   = iz1_q;
      // After the shift the MSB is the hidden one; keep the bits below it.
      norm2_d = (WID-1)'(mag1_q << lz);
      e2_d    = EW'(WID - 1) - lz;
    end
  end

  // Stage 3: round to nearest even, bias, saturate to infinity, set flags.
  always_comb begin
    ext    = {norm2_q, 11'b0};
    frac   = ext[WID+9:WID];
    g_bit  = ext[WID-1];
    s_bit  = |ext[WID-2:0];
    rnd_up = g_bit & (s_bit | frac[0]);
    frac_r = {1'b0, frac} + {10'b0, rnd_up};
    // A carry out of the fraction leaves frac_r[9:0] at zero and bumps e.
    be     = e2_q + EW'(15) + {{(EW-1){1'b0}}, frac_r[10]};

    o_d   = o_q;
    ovf_d = ovf_q;
    inx_d = inx_q;
    if (adv3 && v2_q) begin
      if (iz2_q) begin
        o_d   = 16'h0000;
        ovf_d = 1'b0;
        inx_d = 1'b0;
      end else if (be >= EW'(31)) begin
        o_d   = {sgn2_q, 5'h1F, 10'h000};
        ovf_d = 1'b1;
        inx_d = 1'b1;
      end else begin
        o_d   = {sgn2_q, be[4:0], frac_r[9:0]};
        ovf_d = 1'b0;
        inx_d = g_bit | s_bit;
      end
    end
  end

  // Control and output registers: synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of block order.
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      o_q   <= 16'h0000;
      ovf_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      o_q   <= o_d;
      ovf_q <= ovf_d;
      inx_q <= inx_d;
    end
  end

  // Payload registers of stages 1 and 2.
  always_ff @(posedge clk) begin
    // NOTE: payload flops carry no reset; they are only ever consumed when the
    // matching valid bit is set, and the valid bits are reset.
    sgn1_q  <= sgn1_d;
    mag1_q  <= mag1_d;
    iz1_q   <= iz1_d;
    sgn2_q  <= sgn2_d;
    iz2_q   <= iz2_d;
    norm2_q <= norm2_d;
    e2_q    <= e2_d;
  end

  assign out_valid = v3_q;
  assign o         = o_q;
  assign overflow  = ovf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_i2f16_pipe.sv
// Testbench for i2f16_pipe (WID=16): directed vectors with hand-computed
// results, backpressure, randomised handshakes against an arithmetic model,
// and a mid-pipeline reset.
module tb_i2f16_pipe;

  localparam int WID = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           op;
  logic [WID-1:0] in_int;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    o;
  logic           overflow;
  logic           inexact;

  always #5 clk = ~clk;

  i2f16_pipe #(.WID(WID)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_int    (in_int),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  // Expected result {o, overflow, inexact} plus the cycle it was accepted.
  typedef struct {
    logic [17:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          stall_seen = 1'b0;
  bit          rnd_done = 1'b0;
  logic [17:0] hold_res;
  int          bp_base;
  logic [15:0] rv;
  logic        rop;
  int          mode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference: exponent from the position of the top bit, fraction by integer
  // division with remainder compared against half an ulp.
  function automatic logic [17:0] ref_cvt(input logic op_v, input logic [15:0] v);
    int   mag, e, q, shift, rem, half;
    logic s, inx;
    s   = op_v & v[15];
    mag = s ? (65536 - int'(v)) : int'(v);
    if (mag == 0) return 18'h0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 10) begin
      q   = mag << (10 - e);
      inx = 1'b0;
    end else begin
      shift = e - 10;
      q     = mag >> shift;
      rem   = mag - (q << shift);
      half  = 1 << (shift - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      inx = (rem != 0);
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e + 15 >= 31) return {s, 5'h1F, 10'h000, 2'b11};
    return {s, 5'(e + 15), 10'(q - 1024), 1'b0, inx};
  endfunction

  // Present one word; record its expected result when it is accepted.
  task automatic send(input logic op_v, input logic [15:0] v, input logic [17:0] res);
    int waited = 0;
    in_valid = 1'b1;
    op       = op_v;
    in_int   = v;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back('{res: res, cyc: cyc});
      n_in++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard compare, latency, stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_in = n_in - exp_q.size();
      exp_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen)
        check("stall_hold", 32'({out_valid, o, overflow, inexact}), 32'({1'b1, hold_res}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("result", 32'({o, overflow, inexact}), 32'(mon_e.res));
          if (chk_lat) check("latency", 32'(cyc - mon_e.cyc), 32'd3);
          n_out++;
        end
      end
      stall_seen = out_valid && !out_ready;
      hold_res   = {o, overflow, inexact};
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 1'b0;
    in_int    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o",         32'(o),         32'd0);
    check("rst_flags",     32'({overflow, inexact}), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned basics, tie-to-even, round-up; then signed; then the top edge.
    chk_lat = 1'b1;
    send(1'b0, 16'd0,     {16'h0000, 2'b00});
    send(1'b0, 16'd1,     {16'h3C00, 2'b00});
    send(1'b0, 16'd3,     {16'h4200, 2'b00});
    send(1'b0, 16'd2048,  {16'h6800, 2'b00});
    send(1'b0, 16'd2049,  {16'h6800, 2'b01});
    send(1'b0, 16'd2051,  {16'h6802, 2'b01});
    send(1'b1, 16'hFFFF,  {16'hBC00, 2'b00});
    send(1'b1, 16'h8000,  {16'hF800, 2'b00});
    send(1'b1, 16'h7FFF,  {16'h7800, 2'b01});
    send(1'b0, 16'hFFE0,  {16'h7BFF, 2'b00});
    send(1'b0, 16'hFFF0,  {16'h7C00, 2'b11});
    send(1'b0, 16'hFFFF,  {16'h7C00, 2'b11});
    send(1'b0, 16'd4097,  {16'h6C00, 2'b01});
    send(1'b0, 16'd4099,  {16'h6C01, 2'b01});
    drain("drain_directed");

    // Backpressure: six words against a consumer stalled for five cycles.
    chk_lat = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bp_base   = n_in;
    fork
      begin
        send(1'b0, 16'd6,     {16'h4600, 2'b00});
        send(1'b0, 16'd4097,  {16'h6C00, 2'b01});
        send(1'b0, 16'd4099,  {16'h6C01, 2'b01});
        send(1'b0, 16'h8000,  {16'h7800, 2'b00});
        send(1'b1, 16'hFFF0,  {16'hCC00, 2'b00});
        send(1'b1, 16'd5,     {16'h4500, 2'b00});
      end
    join_none
    repeat (4) @(negedge clk);
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_accepted",     32'(n_in - bp_base), 32'd3);
    check("bp_out_valid",    32'(out_valid), 32'd1);
    check("bp_first_o",      32'({o, overflow, inexact}), 32'({16'h4600, 2'b00}));
    @(negedge clk);
    #1;
    check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain("drain_backpressure");
    check("bp_all_out", 32'(n_out), 32'(n_in));

    // Random handshakes and operands against the model.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          rop  = 1'($urandom_range(0, 1));
          mode = $urandom_range(0, 3);
          case (mode)
            0:       rv = 16'($urandom);
            1:       rv = 16'($urandom_range(0, 4095));
            2:       rv = 16'($urandom_range(65472, 65535));
            default: rv = 16'($urandom_range(2040, 2060));
          endcase
          send(rop, rv, ref_cvt(rop, rv));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    // Reset with three words in flight.
    @(posedge clk);
    #1;
    send(1'b0, 16'd1, {16'h3C00, 2'b00});
    send(1'b0, 16'd3, {16'h4200, 2'b00});
    send(1'b0, 16'd6, {16'h4600, 2'b00});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_o",         32'(o),         32'd0);
    check("mid_rst_flags",     32'({overflow, inexact}), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(1'b1, 16'hFFF0, {16'hCC00, 2'b00});
    drain("drain_after_reset");

    check("io_count", 32'(n_out), 32'(n_in));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2f16_pipe.md
Name: i2f16_pipe

Overview:
- Three-stage pipelined integer-to-FP16 converter with valid/ready handshakes; it is the conversion partner of the FP16-to-integer unit.
- Accepts a signed or unsigned WID-bit integer and produces an IEEE 754 binary16 value (1/5/10, bias 15), rounded to nearest-even.
- Reports overflow and inexact flags.
- Feeds FP16 operands into the fp16Pkg datapath (FP16 type) and supports full-throughput streaming with backpressure.

Parameters:
- WID, 16, integer input width; legal range 8..32.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- op  in  1  1 = signed (two's complement), 0 = unsigned; sampled with in_int
- in_int  in  WID  integer operand
- out_valid  out  1  o/flags valid
- out_ready  in  1  consumer accepts output this cycle
- o  out  16  FP16 result (FP16 type)
- overflow  out  1  magnitude rounded to at least 65536; o is ±infinity
- inexact  out  1  result not exactly equal to input

Behaviour:
- Reset (rst_n=0 at posedge): v1, v2 and v3 cleared; o, overflow and inexact cleared to 0. Reset overrides any transfer in that cycle. A mid-pipeline reset discards in-flight data with no partial output.
- Stage enables: adv3 = !v3 | out_ready; adv2 = !v2 | adv3; adv1 = !v1 | adv2; in_ready = adv1 (combinational, no dependency on in_valid).
- Transfers occur on in_valid&in_ready and on out_valid&out_ready. Each stage loads from its predecessor when its adv is high. Its valid becomes the predecessor's valid, so bubbles collapse.
- A stage that is not advancing holds data and valid unchanged. out_valid = v3. o and flags are stable while out_valid&!out_ready.
- Latency: 3 cycles from accepting transfer to out_valid with no backpressure. Throughput: 1 per cycle.
- Stage 1:
  - sgn = op & in_int[WID-1].
  - mag = sgn ? -in_int : in_int, as a WID-bit unsigned value. The most negative signed value yields 2^(WID-1) exactly.
  - iz = (in_int==0).
- Stage 2:
  - lz = leading-zero count of mag.
  - norm = mag << lz, so the MSB is 1 unless iz.
  - e = WID-1-lz, unbiased.
- Stage 3:
  - frac = norm[WID-2:WID-11], zero-padded on the right when WID<12.
  - G = next lower bit; S = OR of all remaining lower bits.
  - Round up when G&(S|frac[0]). A carry out of frac gives frac=0, e=e+1.
  - be = e+15.
  - If be>=31: o = {sgn,5'h1F,10'h0}, overflow=1, inexact=1.
  - Else o = {sgn,be[4:0],frac}, overflow=0, inexact=G|S.
  - If iz: o = 16'h0000, flags 0. No negative zero is produced.
- Subnormals never arise: every integer ≥1 is ≥ 2^0.
- For WID=16, unsigned inputs 65520..65535 overflow and signed inputs never overflow.

Test Plan:
- WID=16, out_ready=1. Inputs op=0 with 0, 1, 3, 2048, 2049, 2051, in consecutive cycles. Required: out_valid from cycle 3 onward, results 0x0000, 0x3C00, 0x4200, 0x6800, 0x6800 (inexact=1, tie to even), 0x6802 (inexact=1) in order.
- Input op=1 with 0xFFFF, then 0x8000, then 0x7FFF. Required: 0xBC00; 0xF800 (exact); 0x7800 with inexact=1 (32767 rounds to 32768).
- Input op=0 with 0xFFE0 (65504), then 0xFFF0, then 0xFFFF. Required: 0x7BFF with flags 0; 0x7C00 with overflow=1, inexact=1; 0x7C00 with overflow=1, inexact=1.
- Backpressure: stream 6 words with out_ready held 0 for 5 cycles, then released. Required:
  - in_ready drops after 3 words are accepted.
  - o is stable while stalled.
  - All 6 results emerge in order, with no loss or duplication.
- Random in_valid/out_ready toggling, 10k random op/in_int values. Output sequence matches a reference model (round-to-nearest-even, flags as specified).
- rst_n low for 1 cycle while 3 words are in flight. Required:
  - Next cycle: out_valid=0, o=0, flags 0, in_ready=1.
  - No stale output appears afterward.
  - A new input yields a correct result 3 cycles later.
